// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit -- iterative shift-add multiplier / multiply-accumulate unit.
//
// Computes RESULT = (SRC_A * SRC_B + (ACC ? SRC_C : 0)) mod 2^WIDTH using one
// shift-add step per clock. The latency is fixed: START accepted at edge E0,
// WIDTH RUN edges, then a single write-back cycle. Back-to-back operations
// therefore complete every WIDTH+2 cycles.
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RESETN   in   synchronous active-low reset
//   START    in   begin an operation (sampled only in IDLE)
//   ACC      in   0 = MUL (A*B), 1 = MLA (A*B+C)
//   SRC_A    in   multiplicand
//   SRC_B    in   multiplier
//   SRC_C    in   accumulate addend
//   DEST_IN  in   destination register index
//   RESULT   out  product / accumulated result (held until next completion)
//   DEST     out  captured destination index (held until next completion)
//   WE       out  one-cycle register-file write enable in the write-back cycle
//   BUSY     out  high in RUN and write-back
//   DONE     out  one-cycle completion pulse, coincident with WE
//   FLAG_N   out  RESULT[WIDTH-1] of the last completed operation
//   FLAG_Z   out  RESULT == 0 for the last completed operation
// -----------------------------------------------------------------------------
module mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             START,
   input  logic             ACC,
   input  logic [WIDTH-1:0] SRC_A,
   input  logic [WIDTH-1:0] SRC_B,
   input  logic [WIDTH-1:0] SRC_C,
   input  logic [3:0]       DEST_IN,
   output logic [WIDTH-1:0] RESULT,
   output logic [3:0]       DEST,
   output logic             WE,
   output logic             BUSY,
   output logic             DONE,
   output logic             FLAG_N,
   output logic             FLAG_Z
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q,    state_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic [WIDTH-1:0] mcand_q,    mcand_d;
   logic [WIDTH-1:0] mplier_q,   mplier_d;
   logic [WIDTH-1:0] acc_q,      acc_d;
   logic [3:0]       dest_cap_q, dest_cap_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic [3:0]       dest_q,     dest_d;
   logic             we_q,       we_d;
   logic             done_q,     done_d;
   logic             busy_q,     busy_d;
   logic             flag_n_q,   flag_n_d;
   logic             flag_z_q,   flag_z_d;

   // One shift-add step: add the (already shifted) multiplicand when the
   // current multiplier LSB is set. Wraps modulo 2^WIDTH by construction.
   logic [WIDTH-1:0] acc_step;
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves a
      // signal unassigned; otherwise synthesis infers latches.
      state_d    = state_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      dest_cap_d = dest_cap_q;
      result_d   = result_q;
      dest_d     = dest_q;
      we_d       = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;
      flag_n_d   = flag_n_q;
      flag_z_d   = flag_z_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               // Operands are latched here so later input changes cannot
               // disturb the running operation.
               state_d    = S_RUN;
               cnt_d      = '0;
               mcand_d    = SRC_A;
               mplier_d   = SRC_B;
               acc_d      = ACC ? SRC_C : '0;
               dest_cap_d = DEST_IN;
               busy_d     = 1'b1;
            end
         end

         S_RUN: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Last step: the outputs are loaded from the final sum so that
               // they are valid during the write-back cycle itself.
               state_d  = S_WB;
               cnt_d    = '0;
               we_d     = 1'b1;
               done_d   = 1'b1;
               result_d = acc_step;
               dest_d   = dest_cap_q;
               flag_n_d = acc_step[WIDTH-1];
               flag_z_d = (acc_step == '0);
            end
         end

         S_WB: begin
            // START is deliberately not looked at here.
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         dest_cap_q <= '0;
         result_q   <= '0;
         dest_q     <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         flag_n_q   <= 1'b0;
         flag_z_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         dest_cap_q <= dest_cap_d;
         result_q   <= result_d;
         dest_q     <= dest_d;
         we_q       <= we_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         flag_n_q   <= flag_n_d;
         flag_z_q   <= flag_z_d;
      end
   end

   assign RESULT = result_q;
   assign DEST   = dest_q;
   assign WE     = we_q;
   assign DONE   = done_q;
   assign BUSY   = busy_q;
   assign FLAG_N = flag_n_q;
   assign FLAG_Z = flag_z_q;

endmodule
